// File: rtl/mem_req_initiator.sv
// mem_req_initiator
//   Initiator side of the CPU memory-request interface. Takes one load/store
//   command at a time from the core (valid/ready), drives a single request
//   onto the memory interface, and for loads captures the big-endian read
//   word, aligns it and sign/zero-extends it to 48 bits. The result is
//   returned on a valid/ready response port (stores return 0).
// Ports
//   clk, rst_n                     clock (posedge) / async active-low reset
//   cmd_valid, cmd_ready           command handshake
//   cmd_write, cmd_size,
//   cmd_sign_ext, cmd_addr,
//   cmd_wdata                      command payload (store data right-aligned)
//   resp_valid, resp_ready,
//   resp_rdata                     response handshake and load result
//   mem_addr, mem_req_data_size,
//   mem_req_write, mem_data        memory request (write strobe is one cycle)
//   mem_rdata                      memory read word, byte at mem_addr in [47:40]
module mem_req_initiator #(
  parameter int ADDR_WIDTH = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [1:0]            cmd_size,
  input  logic                  cmd_sign_ext,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [47:0]           cmd_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [47:0]           resp_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [1:0]            mem_req_data_size,
  output logic                  mem_req_write,
  output logic [47:0]           mem_data,
  input  logic [47:0]           mem_rdata
);

  localparam int CNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RD_LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             write_r;
  logic             sign_r;

  // Keeps only the bytes that belong to the requested access size.
  function automatic logic [47:0] size_mask(input logic [1:0] sz);
    logic [47:0] m;
    case (sz)
      2'd0:    m = 48'h0000_0000_00FF;
      2'd1:    m = 48'h0000_0000_FFFF;
      2'd2:    m = 48'h0000_FFFF_FFFF;
      2'd3:    m = 48'hFFFF_FFFF_FFFF;
      default: m = 48'hFFFF_FFFF_FFFF;
    endcase
    return m;
  endfunction

  // The field always starts at bit 47 (big-endian), so its MSB is rd[47]
  // for every size; 48-bit loads need no extension at all.
  function automatic logic [47:0] load_extend(input logic [47:0] rd,
                                              input logic [1:0]  sz,
                                              input logic        sx);
    logic [47:0] r;
    logic        fill;
    fill = sx & rd[47];
    case (sz)
      2'd0:    r = {{40{fill}}, rd[47:40]};
      2'd1:    r = {{32{fill}}, rd[47:32]};
      2'd2:    r = {{16{fill}}, rd[47:16]};
      2'd3:    r = rd;
      default: r = rd;
    endcase
    return r;
  endfunction

  // Request/response sequencer; every output is a register of this block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r           <= ST_IDLE;
      cnt_r             <= '0;
      write_r           <= 1'b0;
      sign_r            <= 1'b0;
      cmd_ready         <= 1'b1;
      resp_valid        <= 1'b0;
      resp_rdata        <= 48'd0;
      mem_addr          <= '0;
      mem_req_data_size <= 2'd0;
      mem_req_write     <= 1'b0;
      mem_data          <= 48'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          mem_req_write <= 1'b0;
          if (cmd_valid) begin
            mem_addr          <= cmd_addr;
            mem_req_data_size <= cmd_size;
            mem_data          <= cmd_wdata & size_mask(cmd_size);
            write_r           <= cmd_write;
            sign_r            <= cmd_sign_ext;
            // Strobe is raised here so it is high exactly during ISSUE.
            mem_req_write     <= cmd_write;
            cmd_ready         <= 1'b0;
            state_r           <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          mem_req_write <= 1'b0;
          if (write_r) begin
            resp_rdata <= 48'd0;
            resp_valid <= 1'b1;
            state_r    <= ST_RESP;
          end else begin
            cnt_r   <= CNT_INIT;
            state_r <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          mem_req_write <= 1'b0;
          if (cnt_r == '0) begin
            resp_rdata <= load_extend(mem_rdata, mem_req_data_size, sign_r);
            resp_valid <= 1'b1;
            state_r    <= ST_RESP;
          end else begin
            cnt_r <= cnt_r - 1'b1;
          end
        end
        ST_RESP: begin
          mem_req_write <= 1'b0;
          if (resp_ready) begin
            resp_valid <= 1'b0;
            cmd_ready  <= 1'b1;
            state_r    <= ST_IDLE;
          end
        end
        default: begin
          state_r       <= ST_IDLE;
          cmd_ready     <= 1'b1;
          resp_valid    <= 1'b0;
          mem_req_write <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_req_initiator.sv
// tb_mem_req_initiator
//   Two initiators (RD_LATENCY 1 and 3), each attached to a 64 KiB big-endian
//   byte memory responder. Expected responses come from a byte-array
//   reference model and are queued at command acceptance; a monitor pops
//   and compares whenever a response handshake occurs.
module tb_mem_req_initiator;

  localparam int AW = 32;

  typedef struct packed {
    logic [47:0] data;
    int          first_cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n             [2];
  logic        cmd_valid         [2];
  logic        cmd_ready         [2];
  logic        cmd_write         [2];
  logic [1:0]  cmd_size          [2];
  logic        cmd_sign_ext      [2];
  logic [AW-1:0] cmd_addr        [2];
  logic [47:0] cmd_wdata         [2];
  logic        resp_valid        [2];
  logic        resp_ready        [2];
  logic [47:0] resp_rdata        [2];
  logic [AW-1:0] mem_addr        [2];
  logic [1:0]  mem_req_data_size [2];
  logic        mem_req_write     [2];
  logic [47:0] mem_data          [2];
  logic [47:0] mem_rdata         [2];

  logic [7:0]        mem     [2][65536];
  logic [7:0]        ref_mem [2][65536];
  logic [2:0][47:0]  pipe_d  [2];
  logic [2:0]        pipe_v  [2];
  logic              acc_d   [2];
  logic [47:0]       junk;
  logic              stall   [2];
  exp_t              q       [2][$];
  int                strobes [2];
  int                stores  [2];
  int                cyc = 0;
  int                checks = 0;
  int                errors = 0;

  // Free-running clock.
  always #5 clk = ~clk;

  mem_req_initiator #(.ADDR_WIDTH(AW), .RD_LATENCY(1)) u0 (
    .clk(clk), .rst_n(rst_n[0]),
    .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_write(cmd_write[0]),
    .cmd_size(cmd_size[0]), .cmd_sign_ext(cmd_sign_ext[0]), .cmd_addr(cmd_addr[0]),
    .cmd_wdata(cmd_wdata[0]), .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .mem_addr(mem_addr[0]),
    .mem_req_data_size(mem_req_data_size[0]), .mem_req_write(mem_req_write[0]),
    .mem_data(mem_data[0]), .mem_rdata(mem_rdata[0])
  );

  mem_req_initiator #(.ADDR_WIDTH(AW), .RD_LATENCY(3)) u1 (
    .clk(clk), .rst_n(rst_n[1]),
    .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_write(cmd_write[1]),
    .cmd_size(cmd_size[1]), .cmd_sign_ext(cmd_sign_ext[1]), .cmd_addr(cmd_addr[1]),
    .cmd_wdata(cmd_wdata[1]), .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .mem_addr(mem_addr[1]),
    .mem_req_data_size(mem_req_data_size[1]), .mem_req_write(mem_req_write[1]),
    .mem_data(mem_data[1]), .mem_rdata(mem_rdata[1])
  );

  // Read data is only meaningful RD_LATENCY cycles after ISSUE; junk otherwise.
  assign mem_rdata[0] = pipe_v[0][0] ? pipe_d[0][0] : junk;
  assign mem_rdata[1] = pipe_v[1][2] ? pipe_d[1][2] : junk;

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'd3) ? 6 : (1 << s);
  endfunction

  function automatic int lat(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic logic [47:0] mem_rd6(input int i, input logic [AW-1:0] a);
    logic [47:0] r;
    logic [15:0] ix;
    r = 48'd0;
    for (int k = 0; k < 6; k++) begin
      ix = 16'(a + 32'(k));
      r[47-8*k -: 8] = mem[i][ix];
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, expv);
    end
  endtask

  // Reference model: store bytes MSB-first starting at addr, 16-bit wrap.
  task automatic ref_store(input int i, input logic [1:0] sz, input logic [AW-1:0] a,
                           input logic [47:0] wd);
    int n;
    logic [15:0] ix;
    n = nbytes(sz);
    for (int k = 0; k < n; k++) begin
      ix = 16'(a + 32'(k));
      ref_mem[i][ix] = 8'(wd >> (8 * (n - 1 - k)));
    end
  endtask

  function automatic logic [47:0] ref_load(input int i, input logic [1:0] sz, input logic sx,
                                           input logic [AW-1:0] a);
    int n;
    logic [63:0] v;
    logic [15:0] ix;
    n = nbytes(sz);
    v = 64'd0;
    for (int k = 0; k < n; k++) begin
      ix = 16'(a + 32'(k));
      v = (v << 8) | 64'(ref_mem[i][ix]);
    end
    if (sx && n < 6 && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
    return v[47:0];
  endfunction

  // Memory responder: write strobes into mem, launch the read pipeline after ISSUE.
  initial begin
    int n;
    logic [15:0] ix;
    logic [47:0] rd;
    acc_d[0] = 1'b0; acc_d[1] = 1'b0;
    strobes[0] = 0; strobes[1] = 0;
    pipe_v[0] = 3'd0; pipe_v[1] = 3'd0;
    junk = 48'd0;
    forever begin
      @(posedge clk);
      junk <= {16'($urandom), $urandom};
      for (int i = 0; i < 2; i++) begin
        rd = mem_rd6(i, mem_addr[i]);
        pipe_d[i] <= {pipe_d[i][1:0], rd};
        pipe_v[i] <= {pipe_v[i][1:0], acc_d[i]};
        acc_d[i] = cmd_valid[i] & cmd_ready[i] & rst_n[i];
        if (mem_req_write[i]) begin
          strobes[i]++;
          n = nbytes(mem_req_data_size[i]);
          chk("mem_data_mask", 64'(mem_data[i] >> (8 * n)), 64'd0);
          for (int k = 0; k < n; k++) begin
            ix = 16'(mem_addr[i] + 32'(k));
            mem[i][ix] = 8'(mem_data[i] >> (8 * (n - 1 - k)));
          end
        end
      end
    end
  end

  // Cycle counter used for latency checks.
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Random response back-pressure unless a stall is forced.
  initial forever begin
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++)
      resp_ready[i] = stall[i] ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // Response monitor: latency, stability under back-pressure, data, busy rules.
  initial begin
    logic        prev_v     [2];
    logic        prev_stall [2];
    logic [47:0] prev_d     [2];
    exp_t        e;
    for (int i = 0; i < 2; i++) begin
      prev_v[i] = 1'b0; prev_stall[i] = 1'b0; prev_d[i] = 48'd0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!rst_n[i]) begin
          prev_v[i] = 1'b0;
          prev_stall[i] = 1'b0;
          continue;
        end
        if (prev_stall[i]) begin
          chk("stall_valid", 64'(resp_valid[i]), 64'd1);
          chk("stall_data", 64'(resp_rdata[i]), 64'(prev_d[i]));
        end
        if (resp_valid[i]) begin
          chk("resp_cmd_ready", 64'(cmd_ready[i]), 64'd0);
          chk("resp_no_strobe", 64'(mem_req_write[i]), 64'd0);
          if (q[i].size() == 0) begin
            chk("resp_unexpected", 64'(q[i].size()), 64'd1);
          end else begin
            if (!prev_v[i]) chk("resp_latency", 64'(cyc), 64'(q[i][0].first_cyc));
            if (resp_ready[i]) begin
              e = q[i].pop_front();
              chk("resp_data", 64'(resp_rdata[i]), 64'(e.data));
            end
          end
        end
        prev_stall[i] = resp_valid[i] & ~resp_ready[i];
        prev_v[i] = resp_valid[i];
        prev_d[i] = resp_rdata[i];
      end
    end
  end

  task automatic wait_ready(input int i);
    int t;
    t = 0;
    @(negedge clk);
    while (!cmd_ready[i] && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) chk("cmd_ready_timeout", 64'(t), 64'd0);
  endtask

  // Issue one command, push its expected response.
  task automatic do_cmd(input int i, input logic wr, input logic [1:0] sz, input logic sx,
                        input logic [AW-1:0] a, input logic [47:0] wd,
                        input logic use_exp, input logic [47:0] expv);
    exp_t e;
    wait_ready(i);
    cmd_write[i] = wr; cmd_size[i] = sz; cmd_sign_ext[i] = sx;
    cmd_addr[i] = a; cmd_wdata[i] = wd; cmd_valid[i] = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid[i] = 1'b0;
    cmd_wdata[i] = {16'($urandom), $urandom};
    cmd_addr[i] = $urandom;
    chk("accept_drops_ready", 64'(cmd_ready[i]), 64'd0);
    if (wr) begin
      ref_store(i, sz, a, wd);
      e.data = 48'd0;
      e.first_cyc = cyc + 1;
      stores[i]++;
    end else begin
      e.data = use_exp ? expv : ref_load(i, sz, sx, a);
      e.first_cyc = cyc + 1 + lat(i);
    end
    q[i].push_back(e);
  endtask

  task automatic rand_run(input int i, input int n);
    for (int k = 0; k < n; k++)
      do_cmd(i, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             $urandom, {16'($urandom), $urandom}, 1'b0, 48'd0);
  endtask

  task automatic drain(input int i);
    int t;
    t = 0;
    while ((q[i].size() != 0 || !cmd_ready[i]) && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) chk("drain_timeout", 64'(t), 64'd0);
  endtask

  // Main stimulus sequence.
  initial begin
    logic [7:0] b;
    int s0;
    int t;
    for (int i = 0; i < 2; i++) begin
      rst_n[i] = 1'b0; cmd_valid[i] = 1'b0; cmd_write[i] = 1'b0; cmd_size[i] = 2'd0;
      cmd_sign_ext[i] = 1'b0; cmd_addr[i] = '0; cmd_wdata[i] = 48'd0;
      resp_ready[i] = 1'b0; stall[i] = 1'b0; stores[i] = 0;
      for (int a = 0; a < 65536; a++) begin
        b = 8'($urandom);
        mem[i][a] = b;
        ref_mem[i][a] = b;
      end
    end
    #12;
    for (int i = 0; i < 2; i++) begin
      chk("rst_cmd_ready", 64'(cmd_ready[i]), 64'd1);
      chk("rst_resp_valid", 64'(resp_valid[i]), 64'd0);
      chk("rst_mem_req_write", 64'(mem_req_write[i]), 64'd0);
      chk("rst_resp_rdata", 64'(resp_rdata[i]), 64'd0);
      chk("rst_mem_addr", 64'(mem_addr[i]), 64'd0);
      chk("rst_mem_size", 64'(mem_req_data_size[i]), 64'd0);
      chk("rst_mem_data", 64'(mem_data[i]), 64'd0);
    end
    @(negedge clk);
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;

    // 32-bit store then zero-extended load
    do_cmd(0, 1'b1, 2'd2, 1'b0, 32'h10, 48'h0000_DEAD_BEEF, 1'b0, 48'd0);
    do_cmd(0, 1'b0, 2'd2, 1'b0, 32'h10, 48'd0, 1'b1, 48'h0000_DEAD_BEEF);
    // byte store, sign- and zero-extended loads
    do_cmd(0, 1'b1, 2'd0, 1'b0, 32'h20, 48'h80, 1'b0, 48'd0);
    do_cmd(0, 1'b0, 2'd0, 1'b1, 32'h20, 48'd0, 1'b1, 48'hFFFF_FFFF_FF80);
    do_cmd(0, 1'b0, 2'd0, 1'b0, 32'h20, 48'd0, 1'b1, 48'h0000_0000_0080);
    // halfword store across the top of the 16-bit memory
    do_cmd(0, 1'b1, 2'd1, 1'b0, 32'hFFFF, 48'hA55A, 1'b0, 48'd0);
    wait_ready(0);
    chk("wrap_byte_ffff", 64'(mem[0][65535]), 64'hA5);
    chk("wrap_byte_0000", 64'(mem[0][0]), 64'h5A);
    do_cmd(0, 1'b0, 2'd1, 1'b0, 32'hFFFF, 48'd0, 1'b1, 48'h0000_0000_A55A);

    // load held in RESP by resp_ready=0
    drain(0);
    stall[0] = 1'b1;
    s0 = strobes[0];
    do_cmd(0, 1'b0, 2'd2, 1'b1, 32'h10, 48'd0, 1'b1, 48'hFFFF_DEAD_BEEF);
    t = 0;
    while (!resp_valid[0] && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("stall_resp_seen", 64'(resp_valid[0]), 64'd1);
    repeat (5) begin
      @(negedge clk);
      chk("stall_hold_valid", 64'(resp_valid[0]), 64'd1);
      chk("stall_hold_ready", 64'(cmd_ready[0]), 64'd0);
    end
    chk("stall_no_requests", 64'(strobes[0]), 64'(s0));
    stall[0] = 1'b0;
    t = 0;
    @(negedge clk);
    while (!(resp_valid[0] && resp_ready[0]) && t < 50) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk);
    #1;
    chk("stall_release_idle", 64'(cmd_ready[0]), 64'd1);
    chk("stall_release_valid", 64'(resp_valid[0]), 64'd0);

    // reset pulse during WAIT drops the load
    do_cmd(0, 1'b1, 2'd3, 1'b0, 32'h100, 48'h0123_4567_89AB, 1'b0, 48'd0);
    do_cmd(0, 1'b0, 2'd2, 1'b0, 32'h40, 48'd0, 1'b0, 48'd0);
    @(posedge clk);
    #1;
    rst_n[0] = 1'b0;
    #1;
    chk("midrst_resp_valid", 64'(resp_valid[0]), 64'd0);
    chk("midrst_cmd_ready", 64'(cmd_ready[0]), 64'd1);
    chk("midrst_strobe", 64'(mem_req_write[0]), 64'd0);
    q[0].delete();
    @(posedge clk);
    @(negedge clk);
    rst_n[0] = 1'b1;
    do_cmd(0, 1'b0, 2'd3, 1'b1, 32'h100, 48'd0, 1'b1, 48'h0123_4567_89AB);

    // long-latency instance, 48-bit load
    do_cmd(1, 1'b1, 2'd3, 1'b0, 32'h0003_0200, 48'h0123_4567_89AB, 1'b0, 48'd0);
    do_cmd(1, 1'b0, 2'd3, 1'b0, 32'h0000_0200, 48'd0, 1'b1, 48'h0123_4567_89AB);

    // randomized traffic on both instances concurrently
    fork
      rand_run(0, 60);
      rand_run(1, 40);
    join
    drain(0);
    drain(1);
    chk("strobe_count0", 64'(strobes[0]), 64'(stores[0]));
    chk("strobe_count1", 64'(strobes[1]), 64'(stores[1]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
